// File: rtl/tex_mem_arb.sv
// Round-robin arbiter sharing one texture memory unit among NUM_REQS samplers, with per-requester credits.
// Define TEX_MEM_ARB_PERF_EN to build the 64-bit grant/stall counters; otherwise the perf outputs are tied to 0.
module tex_mem_arb #(
  parameter int NUM_REQS      = 4,
  parameter int NUM_LANES     = 4,
  parameter int REQ_INFOW     = 32,
  parameter int W_ADDR_BITS   = 38,
  parameter int FILTER_BITS   = 1,
  parameter int LGSTRIDE_BITS = 2,
  parameter int MAX_PENDING   = 8,
  localparam int IDXW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
  localparam int CNTW = $clog2(MAX_PENDING + 1)
) (
  input  logic                                                         clk,
  input  logic                                                         reset,
  input  logic [NUM_REQS-1:0]                                          req_valid,
  input  logic [NUM_REQS-1:0][NUM_LANES-1:0]                           req_mask,
  input  logic [NUM_REQS-1:0][FILTER_BITS-1:0]                         req_filter,
  input  logic [NUM_REQS-1:0][LGSTRIDE_BITS-1:0]                       req_lgstride,
  input  logic [NUM_REQS-1:0][NUM_LANES-1:0][W_ADDR_BITS-1:0]          req_baseaddr,
  input  logic [NUM_REQS-1:0][NUM_LANES-1:0][3:0][31:0]                req_addr,
  input  logic [NUM_REQS-1:0][REQ_INFOW-1:0]                           req_info,
  output logic [NUM_REQS-1:0]                                          req_ready,
  output logic                                                         mem_req_valid,
  output logic [NUM_LANES-1:0]                                         mem_req_mask,
  output logic [FILTER_BITS-1:0]                                       mem_req_filter,
  output logic [LGSTRIDE_BITS-1:0]                                     mem_req_lgstride,
  output logic [NUM_LANES-1:0][W_ADDR_BITS-1:0]                        mem_req_baseaddr,
  output logic [NUM_LANES-1:0][3:0][31:0]                              mem_req_addr,
  output logic [REQ_INFOW+IDXW-1:0]                                    mem_req_info,
  input  logic                                                         mem_req_ready,
  input  logic                                                         mem_rsp_valid,
  input  logic [NUM_LANES-1:0][3:0][31:0]                              mem_rsp_data,
  input  logic [REQ_INFOW+IDXW-1:0]                                    mem_rsp_info,
  output logic                                                         mem_rsp_ready,
  output logic [NUM_REQS-1:0]                                          rsp_valid,
  output logic [NUM_LANES-1:0][3:0][31:0]                              rsp_data,
  output logic [REQ_INFOW-1:0]                                         rsp_info,
  input  logic [NUM_REQS-1:0]                                          rsp_ready,
  output logic [63:0]                                                  perf_grants,
  output logic [63:0]                                                  perf_stalls
);

  logic [IDXW-1:0]     rr_ptr;
  logic [IDXW-1:0]     lock_idx;
  logic                lock_valid;
  logic [CNTW-1:0]     pending [NUM_REQS];
  logic [NUM_REQS-1:0] eligible;
  logic [NUM_REQS-1:0] pend_inc;
  logic [NUM_REQS-1:0] pend_dec;
  logic [NUM_REQS-1:0] pend_zero;
  logic [IDXW-1:0]     winner;
  logic                any_elig;
  logic                req_fire;
  logic [IDXW-1:0]     rsp_idx;
  logic                rsp_in_range;
  logic                rsp_fire;

  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      eligible[i]  = req_valid[i] && (pending[i] < CNTW'(MAX_PENDING));
      pend_zero[i] = (pending[i] == '0);
    end
  end

  // A stalled grant stays locked so the memory unit never sees the request change under backpressure.
  always_comb begin : winner_sel
    int              cand;
    logic [IDXW-1:0] cand_idx;
    cand     = 0;
    cand_idx = '0;
    winner   = '0;
    any_elig = 1'b0;
    if (lock_valid) begin
      winner   = lock_idx;
      any_elig = 1'b1;
    end else begin
      for (int k = 0; k < NUM_REQS; k++) begin
        cand     = (int'(rr_ptr) + k) % NUM_REQS;
        cand_idx = IDXW'(cand);
        if (!any_elig && eligible[cand_idx]) begin
          winner   = cand_idx;
          any_elig = 1'b1;
        end
      end
    end
  end

  assign mem_req_valid    = !reset && any_elig;
  assign req_fire         = mem_req_valid && mem_req_ready;
  assign mem_req_mask     = req_mask[winner];
  assign mem_req_filter   = req_filter[winner];
  assign mem_req_lgstride = req_lgstride[winner];
  assign mem_req_baseaddr = req_baseaddr[winner];
  assign mem_req_addr     = req_addr[winner];
  assign mem_req_info     = {req_info[winner], winner};

  assign rsp_idx       = mem_rsp_info[IDXW-1:0];
  assign rsp_in_range  = (int'(rsp_idx) < NUM_REQS);
  // Responses carrying an impossible index are swallowed so the memory unit cannot deadlock.
  assign mem_rsp_ready = !reset && (rsp_in_range ? rsp_ready[rsp_idx] : 1'b1);
  assign rsp_fire      = mem_rsp_valid && mem_rsp_ready;
  assign rsp_data      = mem_rsp_data;
  assign rsp_info      = mem_rsp_info[REQ_INFOW+IDXW-1:IDXW];

  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      req_ready[i] = req_fire && (winner == IDXW'(i));
      rsp_valid[i] = !reset && mem_rsp_valid && rsp_in_range && (rsp_idx == IDXW'(i));
      pend_inc[i]  = req_fire && (winner == IDXW'(i));
      pend_dec[i]  = rsp_fire && rsp_in_range && (rsp_idx == IDXW'(i));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr     <= '0;
      lock_valid <= 1'b0;
      lock_idx   <= '0;
      for (int i = 0; i < NUM_REQS; i++) pending[i] <= '0;
    end else begin
      lock_valid <= mem_req_valid && !mem_req_ready;
      lock_idx   <= winner;
      if (req_fire) rr_ptr <= (winner == IDXW'(NUM_REQS - 1)) ? '0 : winner + IDXW'(1);
      for (int i = 0; i < NUM_REQS; i++) begin
        if (pend_inc[i] && !pend_dec[i]) pending[i] <= pending[i] + CNTW'(1);
        else if (pend_dec[i] && !pend_inc[i] && !pend_zero[i]) pending[i] <= pending[i] - CNTW'(1);
      end
    end
  end

`ifdef TEX_MEM_ARB_PERF_EN
  logic [63:0] grants_q;
  logic [63:0] stalls_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grants_q <= '0;
      stalls_q <= '0;
    end else begin
      if (req_fire) grants_q <= grants_q + 64'd1;
      if (mem_req_valid && !mem_req_ready) stalls_q <= stalls_q + 64'd1;
    end
  end

  assign perf_grants = grants_q;
  assign perf_stalls = stalls_q;
`else
  assign perf_grants = '0;
  assign perf_stalls = '0;
`endif

`ifndef SYNTHESIS
  rsp_idx_valid: assert property (@(posedge clk) disable iff (reset) mem_rsp_valid |-> rsp_in_range);
  no_underflow:  assert property (@(posedge clk) disable iff (reset) (pend_dec & ~pend_inc & pend_zero) == '0);
`endif

endmodule

// File: tb/tb_tex_mem_arb.sv
// Scoreboard bench for tex_mem_arb: directed stimulus queues expected grants/responses, a monitor pops them.
module tb_tex_mem_arb;
  localparam int NR   = 4;
  localparam int NL   = 4;
  localparam int IW   = 32;
  localparam int AW   = 38;
  localparam int IDXW = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NR-1:0]                    req_valid;
  logic [NR-1:0][NL-1:0]            req_mask;
  logic [NR-1:0][0:0]               req_filter;
  logic [NR-1:0][1:0]               req_lgstride;
  logic [NR-1:0][NL-1:0][AW-1:0]    req_baseaddr;
  logic [NR-1:0][NL-1:0][3:0][31:0] req_addr;
  logic [NR-1:0][IW-1:0]            req_info;
  logic [NR-1:0]                    req_ready;
  logic                             mem_req_valid;
  logic [NL-1:0]                    mem_req_mask;
  logic [0:0]                       mem_req_filter;
  logic [1:0]                       mem_req_lgstride;
  logic [NL-1:0][AW-1:0]            mem_req_baseaddr;
  logic [NL-1:0][3:0][31:0]         mem_req_addr;
  logic [IW+IDXW-1:0]               mem_req_info;
  logic                             mem_req_ready;
  logic                             mem_rsp_valid;
  logic [NL-1:0][3:0][31:0]         mem_rsp_data;
  logic [IW+IDXW-1:0]               mem_rsp_info;
  logic                             mem_rsp_ready;
  logic [NR-1:0]                    rsp_valid;
  logic [NL-1:0][3:0][31:0]         rsp_data;
  logic [IW-1:0]                    rsp_info;
  logic [NR-1:0]                    rsp_ready;
  logic [63:0]                      perf_grants;
  logic [63:0]                      perf_stalls;

  tex_mem_arb dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_mask(req_mask), .req_filter(req_filter),
    .req_lgstride(req_lgstride), .req_baseaddr(req_baseaddr), .req_addr(req_addr),
    .req_info(req_info), .req_ready(req_ready),
    .mem_req_valid(mem_req_valid), .mem_req_mask(mem_req_mask), .mem_req_filter(mem_req_filter),
    .mem_req_lgstride(mem_req_lgstride), .mem_req_baseaddr(mem_req_baseaddr),
    .mem_req_addr(mem_req_addr), .mem_req_info(mem_req_info), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_info(mem_rsp_info),
    .mem_rsp_ready(mem_rsp_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_info(rsp_info), .rsp_ready(rsp_ready),
    .perf_grants(perf_grants), .perf_stalls(perf_stalls)
  );

  typedef struct packed {
    logic [IW+IDXW-1:0] info;
    logic [NL-1:0]      mask;
    logic [31:0]        addr0;
    logic [AW-1:0]      base0;
  } grant_t;

  typedef struct packed {
    logic [NR-1:0] vec;
    logic [IW-1:0] info;
    logic [31:0]   data0;
  } rsp_t;

  grant_t        grant_q[$];
  rsp_t          rsp_q[$];
  int            checks = 0;
  int            failures = 0;
  int            grants_since_reset = 0;
  logic [NR-1:0] sticky;
  logic [NR-1:0] granted;

  function automatic logic [IW-1:0] info_of(int i);
    return 32'hA5A5_0000 | 32'(i * 17);
  endfunction

  function automatic logic [NL-1:0] mask_of(int i);
    return 4'hF ^ (4'b0001 << i);
  endfunction

  function automatic logic [31:0] addr_of(int i);
    return 32'hB000_0000 | 32'(i << 8);
  endfunction

  function automatic logic [AW-1:0] base_of(int i);
    return 38'h30_0000_0000 | 38'(i << 4);
  endfunction

  function automatic logic [IW-1:0] rsp_info_of(int i);
    return 32'hD00D_0000 | 32'(i);
  endfunction

  function automatic logic [31:0] rsp_data_of(int i);
    return 32'hDA7A_0000 | 32'(i);
  endfunction

  task automatic check_output(string name, logic [63:0] actual, logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic push_grant(int i);
    grant_t g;
    g.info  = {info_of(i), 2'(i)};
    g.mask  = mask_of(i);
    g.addr0 = addr_of(i);
    g.base0 = base_of(i);
    grant_q.push_back(g);
    grants_since_reset++;
  endtask

  task automatic push_rsp(int i);
    rsp_t r;
    r.vec   = 4'b0001 << i;
    r.info  = rsp_info_of(i);
    r.data0 = rsp_data_of(i);
    rsp_q.push_back(r);
  endtask

  task automatic apply_stimulus(logic [NR-1:0] valid, logic [NR-1:0] stick, logic ready,
                                logic rvalid, int ridx, logic [NR-1:0] rready);
    req_valid          = valid;
    sticky             = stick;
    mem_req_ready      = ready;
    mem_rsp_valid      = rvalid;
    mem_rsp_info       = {rsp_info_of(ridx), 2'(ridx)};
    mem_rsp_data       = '0;
    mem_rsp_data[0][0] = rsp_data_of(ridx);
    rsp_ready          = rready;
  endtask

  // Called at a negedge; non-sticky requesters drop valid once their request was accepted.
  task automatic next_cycle();
    granted = req_ready;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~(granted & ~sticky);
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    apply_stimulus(4'b1111, 4'b0000, 1'b1, 1'b1, 1, 4'b1111);
    repeat (2) @(negedge clk);
    check_output("reset_mem_req_valid", 64'(mem_req_valid), 64'd0);
    check_output("reset_req_ready", 64'(req_ready), 64'd0);
    check_output("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check_output("reset_mem_rsp_ready", 64'(mem_rsp_ready), 64'd0);
    check_output("reset_perf_grants", perf_grants, 64'd0);
    apply_stimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 0, 4'b1111);
    @(posedge clk);
    #1;
    reset = 1'b0;
    grants_since_reset = 0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (mem_req_valid && mem_req_ready) begin
          if (grant_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_grant: got info %0h expected no grant", mem_req_info);
          end else begin
            grant_t g;
            g = grant_q.pop_front();
            check_output("grant_info", 64'(mem_req_info), 64'(g.info));
            check_output("grant_mask", 64'(mem_req_mask), 64'(g.mask));
            check_output("grant_addr0", 64'(mem_req_addr[0][0]), 64'(g.addr0));
            check_output("grant_base0", 64'(mem_req_baseaddr[0]), 64'(g.base0));
          end
        end
        if (mem_rsp_valid && mem_rsp_ready && ((rsp_valid & rsp_ready) != '0)) begin
          if (rsp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_rsp: got vec %0h expected no response", rsp_valid);
          end else begin
            rsp_t r;
            r = rsp_q.pop_front();
            check_output("rsp_vec", 64'(rsp_valid), 64'(r.vec));
            check_output("rsp_info", 64'(rsp_info), 64'(r.info));
            check_output("rsp_data0", 64'(rsp_data[0][0]), 64'(r.data0));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < NR; i++) begin
      req_mask[i]     = mask_of(i);
      req_filter[i]   = 1'(i);
      req_lgstride[i] = 2'(i);
      req_info[i]     = info_of(i);
      for (int j = 0; j < NL; j++) begin
        req_baseaddr[i][j] = base_of(i);
        for (int k = 0; k < 4; k++) req_addr[i][j][k] = addr_of(i) + 32'(j * 4 + k);
      end
    end
    sticky  = '0;
    granted = '0;
    reset_dut();

    // Four requesters always valid: strict rotation 0,1,2,3,0.
    apply_stimulus(4'b1111, 4'b1111, 1'b1, 1'b0, 0, 4'b1111);
    for (int k = 0; k < 5; k++) begin
      push_grant(k % 4);
      @(negedge clk);
      check_output("rr_req_ready", 64'(req_ready), 64'(4'b0001 << (k % 4)));
      next_cycle();
    end
    reset_dut();

    // Stall with req1/req2 pending; req0 appears mid-stall but the grant must stay on 1.
    apply_stimulus(4'b0110, 4'b0000, 1'b0, 1'b0, 0, 4'b1111);
    for (int k = 0; k < 5; k++) begin
      if (k == 2) req_valid[0] = 1'b1;
      @(negedge clk);
      check_output("stall_valid", 64'(mem_req_valid), 64'd1);
      check_output("stall_info", 64'(mem_req_info), 64'({info_of(1), 2'd1}));
      check_output("stall_req_ready", 64'(req_ready), 64'd0);
      next_cycle();
    end
    mem_req_ready = 1'b1;
    push_grant(1);
    push_grant(2);
    push_grant(0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_output("unstall_req_ready", 64'(req_ready), 64'(k == 0 ? 4'b0010 : (k == 1 ? 4'b0100 : 4'b0001)));
      next_cycle();
    end
    reset_dut();

    // Credit limit on requester 0; requester 1 is unaffected while 0 is blocked.
    apply_stimulus(4'b0001, 4'b0001, 1'b1, 1'b0, 0, 4'b1111);
    for (int k = 0; k < 8; k++) begin
      push_grant(0);
      @(negedge clk);
      check_output("credit_req_ready", 64'(req_ready), 64'd1);
      next_cycle();
    end
    req_valid = 4'b0011;
    push_grant(1);
    @(negedge clk);
    check_output("credit_other_req", 64'(req_ready), 64'(4'b0010));
    next_cycle();
    apply_stimulus(4'b0001, 4'b0001, 1'b1, 1'b1, 0, 4'b1111);
    push_rsp(0);
    @(negedge clk);
    check_output("credit_blocked", 64'(req_ready), 64'd0);
    check_output("credit_blocked_valid", 64'(mem_req_valid), 64'd0);
    next_cycle();
    mem_rsp_valid = 1'b0;
    push_grant(0);
    @(negedge clk);
    check_output("credit_returned", 64'(req_ready), 64'd1);
    next_cycle();
    reset_dut();

    // Response to requester 2 held off by rsp_ready[2]=0; its credit must not be returned.
    apply_stimulus(4'b0100, 4'b0100, 1'b1, 1'b0, 0, 4'b1111);
    for (int k = 0; k < 8; k++) begin
      push_grant(2);
      @(negedge clk);
      check_output("fill2_req_ready", 64'(req_ready), 64'(4'b0100));
      next_cycle();
    end
    apply_stimulus(4'b0100, 4'b0100, 1'b1, 1'b1, 2, 4'b1011);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_output("rspstall_vec", 64'(rsp_valid), 64'(4'b0100));
      check_output("rspstall_ready", 64'(mem_rsp_ready), 64'd0);
      check_output("rspstall_req_ready", 64'(req_ready), 64'd0);
      next_cycle();
    end
    rsp_ready = 4'b1111;
    push_rsp(2);
    @(negedge clk);
    check_output("rsp2_ready", 64'(mem_rsp_ready), 64'd1);
    check_output("rsp2_req_ready", 64'(req_ready), 64'd0);
    next_cycle();
    mem_rsp_valid = 1'b0;
    push_grant(2);
    @(negedge clk);
    check_output("rsp2_credit_back", 64'(req_ready), 64'(4'b0100));
    next_cycle();
    reset_dut();

    // Simultaneous grant and response on requester 3 at pending=4 leaves exactly 4 credits.
    apply_stimulus(4'b1000, 4'b1000, 1'b1, 1'b0, 0, 4'b1111);
    for (int k = 0; k < 4; k++) begin
      push_grant(3);
      @(negedge clk);
      check_output("fill3_req_ready", 64'(req_ready), 64'(4'b1000));
      next_cycle();
    end
    apply_stimulus(4'b1000, 4'b1000, 1'b1, 1'b1, 3, 4'b1111);
    push_grant(3);
    push_rsp(3);
    @(negedge clk);
    check_output("incdec_req_ready", 64'(req_ready), 64'(4'b1000));
    check_output("incdec_rsp_ready", 64'(mem_rsp_ready), 64'd1);
    next_cycle();
    mem_rsp_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) push_grant(3);
      @(negedge clk);
      check_output("incdec_credit", 64'(req_ready), 64'(k < 4 ? 4'b1000 : 4'b0000));
      next_cycle();
    end
    reset_dut();

    // Asynchronous reset in the middle of a stall.
    apply_stimulus(4'b0010, 4'b0000, 1'b0, 1'b1, 1, 4'b0000);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_output("prestall_valid", 64'(mem_req_valid), 64'd1);
      check_output("prestall_rsp_vec", 64'(rsp_valid), 64'(4'b0010));
      next_cycle();
    end
    #2;
    reset = 1'b1;
    #1;
    check_output("async_mem_req_valid", 64'(mem_req_valid), 64'd0);
    check_output("async_req_ready", 64'(req_ready), 64'd0);
    check_output("async_rsp_valid", 64'(rsp_valid), 64'd0);
    check_output("async_mem_rsp_ready", 64'(mem_rsp_ready), 64'd0);
    apply_stimulus(4'b0000, 4'b0000, 1'b0, 1'b0, 0, 4'b1111);
    @(posedge clk);
    #1;
    reset = 1'b0;
    grants_since_reset = 0;
    apply_stimulus(4'b1100, 4'b0000, 1'b1, 1'b0, 0, 4'b1111);
    push_grant(2);
    push_grant(3);
    @(negedge clk);
    check_output("post_reset_first", 64'(req_ready), 64'(4'b0100));
    next_cycle();
    @(negedge clk);
    check_output("post_reset_second", 64'(req_ready), 64'(4'b1000));
    next_cycle();
    @(negedge clk);
`ifdef TEX_MEM_ARB_PERF_EN
    check_output("perf_grants", perf_grants, 64'(grants_since_reset));
`else
    check_output("perf_grants", perf_grants, 64'd0);
`endif
    check_output("perf_stalls", perf_stalls, 64'd0);
    check_output("grant_q_drained", 64'(grant_q.size()), 64'd0);
    check_output("rsp_q_drained", 64'(rsp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
